// File: rtl/mem_data_access_if.sv
// SRAM-like data bus between the memory-stage controller and the data memory.
// The master issues a request, then waits for addr_ok and data_ok.
interface mem_data_access_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_data_access.sv
// Memory-stage data-access controller: issues the slot-1 load/store on the data bus,
// stalls the pipeline until completion and returns extended load data.
module mem_data_access (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      flush_cause,
    input  logic [3:0]                mem_op_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [31:0]               reg2_i,
    mem_data_access_if.master         bus,
    output logic [31:0]               rdata_o,
    output logic                      rdata_valid_o,
    output logic                      addr_err_o,
    output logic                      stallreq_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned_s;
    logic        exc_flush_s;
    logic        op_valid_s;
    logic        wr_s;
    logic [1:0]  size_s;
    logic [31:0] wdata_s;

    function automatic logic [31:0] load_extend(input logic [3:0] op,
                                                input logic [1:0] lane,
                                                input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            2'd3:    b = raw[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? raw[31:16] : raw[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'h000000, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'h0000, h};
            OP_LW:   res = raw;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Decode alignment, validity and bus fields of the incoming op
    always_comb begin
        misaligned_s = 1'b0;
        wr_s         = 1'b0;
        size_s       = 2'd0;
        wdata_s      = 32'h0000_0000;
        case (mem_op_i)
            OP_LB, OP_LBU: size_s = 2'd0;
            OP_LH, OP_LHU: begin
                size_s       = 2'd1;
                misaligned_s = mem_addr_i[0];
            end
            OP_LW: begin
                size_s       = 2'd2;
                misaligned_s = |mem_addr_i[1:0];
            end
            OP_SB: begin
                wr_s    = 1'b1;
                size_s  = 2'd0;
                wdata_s = {4{reg2_i[7:0]}};
            end
            OP_SH: begin
                wr_s         = 1'b1;
                size_s       = 2'd1;
                wdata_s      = {2{reg2_i[15:0]}};
                misaligned_s = mem_addr_i[0];
            end
            OP_SW: begin
                wr_s         = 1'b1;
                size_s       = 2'd2;
                wdata_s      = reg2_i;
                misaligned_s = |mem_addr_i[1:0];
            end
            default: misaligned_s = 1'b0;
        endcase
        exc_flush_s = flush & flush_cause;
        op_valid_s  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW)
                      && !misaligned_s && !exc_flush_s;
    end

    // Next-state logic of the access FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid_s) state_d = S_REQ;
                else            state_d = S_IDLE;
            end
            S_REQ: begin
                // A request accepted in the flush cycle still owes a response; absorb it.
                if (exc_flush_s)            state_d = bus.data_addr_ok ? S_CANCEL : S_IDLE;
                else if (bus.data_addr_ok)  state_d = S_WAIT;
                else                        state_d = S_REQ;
            end
            S_WAIT: begin
                if (exc_flush_s)            state_d = bus.data_data_ok ? S_IDLE : S_CANCEL;
                else if (bus.data_data_ok)  state_d = S_DONE;
                else                        state_d = S_WAIT;
            end
            S_DONE: state_d = S_IDLE;
            S_CANCEL: begin
                if (bus.data_data_ok) state_d = S_IDLE;
                else                  state_d = S_CANCEL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request field capture and load result latch
    always_comb begin
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        if (state_q == S_IDLE && op_valid_s) begin
            wr_d    = wr_s;
            size_d  = size_s;
            addr_d  = mem_addr_i;
            wdata_d = wdata_s;
            op_d    = mem_op_i;
        end else if (state_q == S_WAIT && bus.data_data_ok && !exc_flush_s) begin
            rdata_d = load_extend(op_q, addr_q[1:0], bus.data_rdata);
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FSM output decode
    always_comb begin
        bus.data_req  = 1'b0;
        stallreq_o    = 1'b0;
        rdata_valid_o = 1'b0;
        case (state_q)
            S_IDLE:  stallreq_o = op_valid_s;
            S_REQ: begin
                bus.data_req = 1'b1;
                stallreq_o   = 1'b1;
            end
            S_WAIT:  stallreq_o = 1'b1;
            S_DONE:  rdata_valid_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            op_q    <= 4'd0;
            rdata_q <= 32'h0000_0000;
        end else begin
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign rdata_o        = rdata_q;
    assign addr_err_o     = misaligned_s;
endmodule

// File: tb/tb_mem_data_access.sv
// Directed bench for mem_data_access: a vector table of single accesses plus
// hand-written sequences for stalls, flushes and reset mid-access.
module tb_mem_data_access;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] bus_rdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        logic        exp_wr;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        flush_cause;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        addr_err_o;
    logic        stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [13];

    mem_data_access_if bus ();

    mem_data_access dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .flush_cause   (flush_cause),
        .mem_op_i      (mem_op_i),
        .mem_addr_i    (mem_addr_i),
        .reg2_i        (reg2_i),
        .bus           (bus),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .addr_err_o    (addr_err_o),
        .stallreq_o    (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        mem_op_i   = v.op;
        mem_addr_i = v.addr;
        reg2_i     = v.reg2;
        #1;
        chk($sformatf("v%0d_err", i), addr_err_o, v.exp_err);
        chk($sformatf("v%0d_stall_T", i), stallreq_o, !v.exp_err);
        if (v.exp_err) begin
            nxt();
            chk($sformatf("v%0d_noreq", i), bus.data_req, 1'b0);
            chk($sformatf("v%0d_nostall", i), stallreq_o, 1'b0);
            mem_op_i = 4'd0;
        end else begin
            nxt();
            bus.data_addr_ok = 1'b1;
            #1;
            chk($sformatf("v%0d_req", i), bus.data_req, 1'b1);
            chk($sformatf("v%0d_wr", i), bus.data_wr, v.exp_wr);
            chk($sformatf("v%0d_size", i), bus.data_size, v.exp_size);
            chk($sformatf("v%0d_addr", i), bus.data_addr, v.addr);
            chk($sformatf("v%0d_wdata", i), bus.data_wdata, v.exp_wdata);
            nxt();
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = v.bus_rdata;
            #1;
            chk($sformatf("v%0d_req_wait", i), bus.data_req, 1'b0);
            chk($sformatf("v%0d_stall_wait", i), stallreq_o, 1'b1);
            nxt();
            bus.data_data_ok = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i), rdata_valid_o, 1'b1);
            chk($sformatf("v%0d_rdata", i), rdata_o, v.exp_rdata);
            chk($sformatf("v%0d_stall_done", i), stallreq_o, 1'b0);
            nxt();
            mem_op_i = 4'd0;
            #1;
            chk($sformatf("v%0d_valid_off", i), rdata_valid_o, 1'b0);
        end
    endtask

    initial begin
        //            op      addr           reg2           bus_rdata      exp_rdata      exp_wdata      sz    wr    err
        vecs[0]  = '{OP_LW,  32'h8000_1004, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 2'd2, 1'b0, 1'b0};
        vecs[1]  = '{OP_LB,  32'h8000_1003, 32'h0000_0000, 32'h80FF_7F01, 32'hFFFF_FF80, 32'h0000_0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{OP_LBU, 32'h8000_1003, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_0080, 32'h0000_0000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{OP_LH,  32'h8000_1002, 32'h0000_0000, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h0000_0000, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{OP_LHU, 32'h8000_1000, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_7F01, 32'h0000_0000, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{OP_LB,  32'h8000_1001, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_007F, 32'h0000_0000, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{OP_LBU, 32'h8000_1002, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_00FF, 32'h0000_0000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{OP_LH,  32'h8000_1000, 32'h0000_0000, 32'h0000_F00F, 32'hFFFF_F00F, 32'h0000_0000, 2'd1, 1'b0, 1'b0};
        vecs[8]  = '{OP_SB,  32'h8000_1001, 32'h1234_56AB, 32'hFFFF_FFFF, 32'h0000_0000, 32'hABAB_ABAB, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{OP_SW,  32'h8000_1000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0000_0000, 32'hCAFE_F00D, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{OP_LW,  32'h8000_1002, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{OP_SH,  32'h8000_1001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0, 1'b1};
        vecs[12] = '{OP_LHU, 32'h8000_1003, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0, 1'b1};

        rst              = 1'b1;
        flush            = 1'b0;
        flush_cause      = 1'b0;
        mem_op_i         = 4'd0;
        mem_addr_i       = 32'h0000_0000;
        reg2_i           = 32'h0000_0000;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.data_req, 1'b0);
        chk("rst_wr", bus.data_wr, 1'b0);
        chk("rst_size", bus.data_size, 2'd0);
        chk("rst_addr", bus.data_addr, 32'h0000_0000);
        chk("rst_wdata", bus.data_wdata, 32'h0000_0000);
        chk("rst_rdata", rdata_o, 32'h0000_0000);
        chk("rst_valid", rdata_valid_o, 1'b0);
        chk("rst_stall", stallreq_o, 1'b0);
        chk("rst_err", addr_err_o, 1'b0);
        rst = 1'b0;
        nxt();

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
            nxt();
        end

        // SH with addr_ok delayed three cycles and a stray data_ok in REQ
        mem_op_i   = OP_SH;
        mem_addr_i = 32'h8000_2002;
        reg2_i     = 32'h1234_5678;
        #1;
        chk("sh_stall_T", stallreq_o, 1'b1);
        chk("sh_err", addr_err_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            bus.data_data_ok = (k == 1);
            if (k >= 1) reg2_i = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("sh_req_%0d", k), bus.data_req, 1'b1);
            chk($sformatf("sh_wdata_%0d", k), bus.data_wdata, 32'h5678_5678);
            chk($sformatf("sh_size_%0d", k), bus.data_size, 2'd1);
            chk($sformatf("sh_wr_%0d", k), bus.data_wr, 1'b1);
            chk($sformatf("sh_addr_%0d", k), bus.data_addr, 32'h8000_2002);
            chk($sformatf("sh_stall_%0d", k), stallreq_o, 1'b1);
        end
        nxt();
        bus.data_data_ok = 1'b0;
        bus.data_addr_ok = 1'b1;
        #1;
        chk("sh_req_acc", bus.data_req, 1'b1);
        nxt();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hAAAA_AAAA;
        #1;
        chk("sh_wait_req", bus.data_req, 1'b0);
        chk("sh_wait_stall", stallreq_o, 1'b1);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk("sh_valid", rdata_valid_o, 1'b1);
        chk("sh_rdata", rdata_o, 32'h0000_0000);
        nxt();
        mem_op_i = 4'd0;
        reg2_i   = 32'h0000_0000;
        nxt();

        // Exception flush in WAIT: late data_ok discarded, next LW accepted after CANCEL
        mem_op_i   = OP_LW;
        mem_addr_i = 32'h8000_3000;
        nxt();
        bus.data_addr_ok = 1'b1;
        nxt();
        bus.data_addr_ok = 1'b0;
        flush            = 1'b1;
        flush_cause      = 1'b1;
        #1;
        chk("xf_wait_stall", stallreq_o, 1'b1);
        nxt();
        flush       = 1'b0;
        flush_cause = 1'b0;
        mem_addr_i  = 32'h8000_3008;
        #1;
        chk("xf_cancel_req", bus.data_req, 1'b0);
        chk("xf_cancel_stall", stallreq_o, 1'b0);
        chk("xf_cancel_valid", rdata_valid_o, 1'b0);
        nxt();
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1111_1111;
        #1;
        chk("xf_cancel2_stall", stallreq_o, 1'b0);
        chk("xf_cancel2_req", bus.data_req, 1'b0);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk("xf_idle_valid", rdata_valid_o, 1'b0);
        chk("xf_idle_accept", stallreq_o, 1'b1);
        nxt();
        bus.data_addr_ok = 1'b1;
        #1;
        chk("xf_new_req", bus.data_req, 1'b1);
        chk("xf_new_addr", bus.data_addr, 32'h8000_3008);
        nxt();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h0BAD_F00D;
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk("xf_new_valid", rdata_valid_o, 1'b1);
        chk("xf_new_rdata", rdata_o, 32'h0BAD_F00D);
        nxt();
        mem_op_i = 4'd0;
        nxt();

        // Branch flush during REQ has no effect
        mem_op_i   = OP_LW;
        mem_addr_i = 32'h8000_4004;
        nxt();
        flush            = 1'b1;
        flush_cause      = 1'b0;
        bus.data_addr_ok = 1'b1;
        #1;
        chk("bf_req", bus.data_req, 1'b1);
        nxt();
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1357_9BDF;
        #1;
        chk("bf_wait_stall", stallreq_o, 1'b1);
        nxt();
        bus.data_data_ok = 1'b0;
        #1;
        chk("bf_valid", rdata_valid_o, 1'b1);
        chk("bf_rdata", rdata_o, 32'h1357_9BDF);
        nxt();
        mem_op_i = 4'd0;
        nxt();

        // Exception flush in REQ withdraws the request
        mem_op_i   = OP_LW;
        mem_addr_i = 32'h8000_5000;
        nxt();
        #1;
        chk("xr_req", bus.data_req, 1'b1);
        flush       = 1'b1;
        flush_cause = 1'b1;
        nxt();
        flush       = 1'b0;
        flush_cause = 1'b0;
        mem_op_i    = 4'd0;
        #1;
        chk("xr_withdrawn", bus.data_req, 1'b0);
        chk("xr_stall", stallreq_o, 1'b0);
        nxt();
        chk("xr_idle_req", bus.data_req, 1'b0);

        // Undefined op code is ignored
        mem_op_i   = 4'd9;
        mem_addr_i = 32'h8000_5001;
        #1;
        chk("op9_stall", stallreq_o, 1'b0);
        chk("op9_err", addr_err_o, 1'b0);
        nxt();
        chk("op9_req", bus.data_req, 1'b0);
        mem_op_i = 4'd0;
        nxt();

        // Reset while waiting for data clears every output
        mem_op_i   = OP_LW;
        mem_addr_i = 32'h8000_6004;
        nxt();
        bus.data_addr_ok = 1'b1;
        nxt();
        bus.data_addr_ok = 1'b0;
        rst              = 1'b1;
        #1;
        chk("rw_wait_stall", stallreq_o, 1'b1);
        nxt();
        mem_op_i = 4'd0;
        #1;
        chk("rw_req", bus.data_req, 1'b0);
        chk("rw_wr", bus.data_wr, 1'b0);
        chk("rw_size", bus.data_size, 2'd0);
        chk("rw_addr", bus.data_addr, 32'h0000_0000);
        chk("rw_wdata", bus.data_wdata, 32'h0000_0000);
        chk("rw_rdata", rdata_o, 32'h0000_0000);
        chk("rw_valid", rdata_valid_o, 1'b0);
        chk("rw_stall", stallreq_o, 1'b0);
        rst = 1'b0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
